// File: rtl/fifo_u_byte_ctrl.sv
// fifo_u_byte_ctrl: byte-wide sequencer for the 1-bit serial FIFO; FIFO_CTRL_TIMEOUT_EN adds a sticky stall timeout (err)
module fifo_u_byte_ctrl #(
  parameter int DEPTH = 64,
  parameter int CW = 7,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic          rd_req,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic          fifo_din,
  output logic          fifo_save,
  output logic          fifo_pop,
  input  logic          fifo_dout,
  input  logic          fifo_full,
  input  logic          fifo_empty,
  input  logic          fifo_busy,
  output logic [CW-1:0] bit_count
`ifdef FIFO_CTRL_TIMEOUT_EN
  ,
  output logic          err
`endif
);
  typedef enum logic [2:0] {IDLE, W_ISSUE, W_WAIT, R_ISSUE, R_WAIT, R_DONE} state_t;
  state_t state;
  logic [7:0] shift, asm_byte;
  logic [2:0] idx;
  logic guard, prio_rd, blocked, w_el, r_el, both, w_win, r_win, exit_wait;
  if (DEPTH < 8 || (2 ** CW) <= DEPTH || TIMEOUT < 1) begin : g_bad_params
    $error("fifo_u_byte_ctrl: illegal DEPTH/CW/TIMEOUT");
  end
  assign w_el = bit_count <= CW'(DEPTH - 8);
  assign r_el = rd_req && bit_count >= CW'(8);
  assign both = w_el && r_el && wr_valid;
  assign w_win = w_el && !blocked && !reset && (!r_el || (wr_valid && !prio_rd));
  assign r_win = r_el && !blocked && !reset && !(w_el && wr_valid && !prio_rd);
  assign wr_ready = state == IDLE && w_win;
  assign exit_wait = !guard && !fifo_busy;
  // pulses are gated by the live flags so none can coincide with busy
  assign fifo_save = state == W_ISSUE && !fifo_busy && !fifo_full;
  assign fifo_pop = state == R_ISSUE && !fifo_busy && !fifo_empty;
  assign fifo_din = fifo_save && shift[0];
  assign rd_valid = state == R_DONE;
`ifdef FIFO_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] stall;
  logic moving;
  assign blocked = err;
  assign moving = fifo_save || fifo_pop || ((state == W_WAIT || state == R_WAIT) && exit_wait);
`else
  assign blocked = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shift <= '0;
      asm_byte <= '0;
      idx <= '0;
      guard <= 1'b0;
      prio_rd <= 1'b0;
      rd_data <= '0;
      bit_count <= '0;
`ifdef FIFO_CTRL_TIMEOUT_EN
      stall <= '0;
      err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (both && (w_win || r_win)) prio_rd <= w_win;
          if (wr_valid && wr_ready) begin
            shift <= wr_data;
            idx <= '0;
            state <= W_ISSUE;
          end else if (r_win) begin
            idx <= '0;
            state <= R_ISSUE;
          end
        end
        W_ISSUE: if (fifo_save) begin
          guard <= 1'b1;
          state <= W_WAIT;
        end
        W_WAIT: begin
          guard <= 1'b0;
          if (exit_wait) begin
            shift <= shift >> 1;
            idx <= idx + 3'd1;
            bit_count <= bit_count + CW'(1);
            state <= idx == 3'd7 ? IDLE : W_ISSUE;
          end
        end
        R_ISSUE: if (fifo_pop) begin
          asm_byte[idx] <= fifo_dout;
          guard <= 1'b1;
          state <= R_WAIT;
        end
        R_WAIT: begin
          guard <= 1'b0;
          if (exit_wait) begin
            idx <= idx + 3'd1;
            bit_count <= bit_count - CW'(1);
            if (idx == 3'd7) rd_data <= asm_byte;
            state <= idx == 3'd7 ? R_DONE : R_ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef FIFO_CTRL_TIMEOUT_EN
      if (state == IDLE || state == R_DONE || moving) stall <= '0;
      else if (stall == TW'(TIMEOUT - 1)) begin
        stall <= '0;
        err <= 1'b1;
        guard <= 1'b0;
        state <= IDLE;
      end else stall <= stall + TW'(1);
`endif
    end
  end
endmodule

// File: tb/tb_fifo_u_byte_ctrl.sv
// tb_fifo_u_byte_ctrl: directed table-driven bench with behavioural 1-bit FIFO models for DEPTH=64 and DEPTH=16
module tb_fifo_u_byte_ctrl;
  typedef struct {
    logic [7:0] d;
    int busy;
    int gap;
    int wlat;
    int rlat;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] wr_data = '0;
  logic wr_valid = 1'b0, rd_req = 1'b0;
  logic wr_ready, rd_valid, fifo_din, fifo_save, fifo_pop, fifo_dout, fifo_full, fifo_empty, fifo_busy;
  logic [7:0] rd_data;
  logic [6:0] bit_count;
  logic [7:0] w16_data = '0;
  logic w16_valid = 1'b0, r16_req = 1'b0;
  logic w16_ready, r16_valid, f16_din, f16_save, f16_pop, f16_dout, f16_full, f16_empty;
  logic [7:0] r16_data;
  logic [4:0] bc16;
`ifdef FIFO_CTRL_TIMEOUT_EN
  logic err, err16;
`endif
  int busy_len = 0, busy_cnt = 0, viol = 0, cyc = 0, nsave = 0, npop = 0;
  int hd = 0, tl = 0, n = 0, hd16 = 0, tl16 = 0, n16 = 0;
  logic mem [64];
  logic mem16 [16];
  logic save_bit [256];
  int save_cyc [256];
  int checks = 0, fails = 0;
  vec_t vt [6];

  always #5 clk = ~clk;

  fifo_u_byte_ctrl u_dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .fifo_din(fifo_din),
    .fifo_save(fifo_save), .fifo_pop(fifo_pop), .fifo_dout(fifo_dout), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_busy(fifo_busy), .bit_count(bit_count)
`ifdef FIFO_CTRL_TIMEOUT_EN
    , .err(err)
`endif
  );

  fifo_u_byte_ctrl #(.DEPTH(16), .CW(5)) u_d16 (
    .clk(clk), .reset(reset), .wr_data(w16_data), .wr_valid(w16_valid), .wr_ready(w16_ready),
    .rd_req(r16_req), .rd_data(r16_data), .rd_valid(r16_valid), .fifo_din(f16_din),
    .fifo_save(f16_save), .fifo_pop(f16_pop), .fifo_dout(f16_dout), .fifo_full(f16_full),
    .fifo_empty(f16_empty), .fifo_busy(1'b0), .bit_count(bc16)
`ifdef FIFO_CTRL_TIMEOUT_EN
    , .err(err16)
`endif
  );

  assign fifo_busy = busy_cnt != 0;
  assign fifo_full = n >= 64;
  assign fifo_empty = n == 0;
  assign fifo_dout = mem[hd];
  assign f16_full = n16 >= 16;
  assign f16_empty = n16 == 0;
  assign f16_dout = mem16[hd16];

  // behavioural serial FIFOs; busy stays high busy_len cycles after each pulse
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      hd <= 0; tl <= 0; n <= 0; busy_cnt <= 0;
      hd16 <= 0; tl16 <= 0; n16 <= 0;
    end else begin
      if (((fifo_save || fifo_pop) && fifo_busy) || (fifo_save && fifo_pop) || (f16_save && f16_pop))
        viol <= viol + 1;
      if (fifo_save) begin
        mem[tl] <= fifo_din;
        tl <= (tl + 1) % 64;
        save_bit[nsave % 256] <= fifo_din;
        save_cyc[nsave % 256] <= cyc;
        nsave <= nsave + 1;
      end
      if (fifo_pop) begin
        hd <= (hd + 1) % 64;
        npop <= npop + 1;
      end
      n <= n + (fifo_save ? 1 : 0) - (fifo_pop ? 1 : 0);
      busy_cnt <= (fifo_save || fifo_pop) ? busy_len : (busy_cnt > 0 ? busy_cnt - 1 : 0);
      if (f16_save) begin
        mem16[tl16] <= f16_din;
        tl16 <= (tl16 + 1) % 16;
      end
      if (f16_pop) hd16 <= (hd16 + 1) % 16;
      n16 <= n16 + (f16_save ? 1 : 0) - (f16_pop ? 1 : 0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr_byte(input logic [7:0] d, output int lat);
    wr_data = d;
    wr_valid = 1'b1;
    lat = 0;
    while (!wr_ready && lat < 200) begin tick; lat++; end
    tick;
    wr_valid = 1'b0;
    lat = 1;
    while (!wr_ready && lat < 200) begin tick; lat++; end
  endtask

  task automatic rd_byte(output int lat);
    rd_req = 1'b1;
    tick;
    rd_req = 1'b0;
    lat = 1;
    while (!rd_valid && lat < 200) begin tick; lat++; end
  endtask

  task automatic w16_byte(input logic [7:0] d);
    w16_data = d;
    w16_valid = 1'b1;
    for (int k = 0; k < 200 && !w16_ready; k++) tick;
    tick;
    w16_valid = 1'b0;
    repeat (25) tick;
  endtask

  initial begin
    int wl, rl, s0, seen, nw, nr, got16;
    logic [7:0] sb, code;
    logic [7:0] got [3];
    logic [7:0] g16 [2];
    vt[0] = '{8'hA5, 0, 3, 25, 25};
    vt[1] = '{8'h3C, 0, 3, 25, 25};
    vt[2] = '{8'hA5, 4, 6, 49, 49};
    vt[3] = '{8'h00, 0, 3, 25, 25};
    vt[4] = '{8'hFF, 4, 6, 49, 49};
    vt[5] = '{8'h81, 0, 3, 25, 25};
    tick;
    tick;
    chk("reset_wr_ready", 32'(wr_ready), 0);
    chk("reset_rd_valid", 32'(rd_valid), 0);
    chk("reset_pulses", 32'({fifo_save, fifo_pop, fifo_din}), 0);
    chk("reset_bit_count", 32'(bit_count), 0);
    chk("reset_rd_data", 32'(rd_data), 0);
    reset = 1'b0;
    tick;
    chk("idle_wr_ready", 32'(wr_ready), 1);
    rd_req = 1'b1;
    r16_req = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      tick;
      if (rd_valid || fifo_pop || r16_valid || f16_pop) seen++;
    end
    rd_req = 1'b0;
    r16_req = 1'b0;
    chk("empty_read_not_granted", seen, 0);
    tick;
    for (int i = 0; i < 6; i++) begin
      busy_len = vt[i].busy;
      s0 = nsave;
      chk("wr_ready_before_write", 32'(wr_ready), 1);
      wr_byte(vt[i].d, wl);
      chk("write_latency", wl, vt[i].wlat);
      chk("bit_count_after_write", 32'(bit_count), 8);
      chk("save_count", nsave - s0, 8);
      sb = '0;
      for (int b = 0; b < 8; b++) sb[b] = save_bit[(s0 + b) % 256];
      chk("saved_bits_lsb_first", 32'(sb), 32'(vt[i].d));
      for (int b = 1; b < 8; b++)
        chk("save_gap", save_cyc[(s0 + b) % 256] - save_cyc[(s0 + b - 1) % 256], vt[i].gap);
      rd_byte(rl);
      chk("read_latency", rl, vt[i].rlat);
      chk("rd_data", 32'(rd_data), 32'(vt[i].d));
      tick;
      chk("rd_valid_one_cycle", 32'(rd_valid), 0);
      chk("bit_count_after_read", 32'(bit_count), 0);
      chk("wr_ready_after_read", 32'(wr_ready), 1);
    end
    busy_len = 0;
    wr_byte(8'h11, wl);
    wr_data = 8'h22;
    wr_valid = 1'b1;
    rd_req = 1'b1;
    nw = 0;
    nr = 0;
    code = 8'h01;
    got[0] = '0; got[1] = '0; got[2] = '0;
    for (int c = 0; c < 400 && nr < 3; c++) begin
      if (rd_valid) begin
        got[nr] = rd_data;
        nr++;
        code = {code[6:0], 1'b0};
      end
      if (wr_valid && wr_ready) begin
        nw++;
        code = {code[6:0], 1'b1};
      end
      tick;
      if (nw == 1) wr_data = 8'h33;
      if (nw == 2) wr_valid = 1'b0;
    end
    rd_req = 1'b0;
    chk("grant_order", 32'(code), 32'h34);
    chk("arb_rd0", 32'(got[0]), 32'h11);
    chk("arb_rd1", 32'(got[1]), 32'h22);
    chk("arb_rd2", 32'(got[2]), 32'h33);
    tick;
    chk("arb_bit_count", 32'(bit_count), 0);
    wr_data = 8'h5A;
    wr_valid = 1'b1;
    tick;
    wr_valid = 1'b0;
    repeat (10) tick;
    chk("bit_count_mid_write", 32'(bit_count), 3);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    chk("abort_bit_count", 32'(bit_count), 0);
    chk("abort_pulses", 32'({fifo_save, fifo_pop}), 0);
    chk("abort_idle_ready", 32'(wr_ready), 1);
    chk("abort_model_empty", n, 0);
    s0 = nsave;
    repeat (5) tick;
    chk("abort_no_pulses", nsave - s0, 0);
    w16_byte(8'h3C);
    w16_byte(8'hFF);
    chk("d16_bit_count_full", 32'(bc16), 16);
    w16_data = 8'h77;
    w16_valid = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      if (w16_ready) seen++;
      tick;
    end
    w16_valid = 1'b0;
    chk("d16_full_wr_ready", seen, 0);
    r16_req = 1'b1;
    got16 = 0;
    g16[0] = '0;
    g16[1] = '0;
    for (int k = 0; k < 200 && got16 < 2; k++) begin
      tick;
      if (r16_valid) begin
        g16[got16] = r16_data;
        got16++;
      end
    end
    r16_req = 1'b0;
    chk("d16_rd0", 32'(g16[0]), 32'h3C);
    chk("d16_rd1", 32'(g16[1]), 32'hFF);
    tick;
    chk("d16_bit_count_empty", 32'(bc16), 0);
    chk("pulse_rule_violations", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
